// File: rtl/wpin_uart_xcvr.sv
// Single-pin word transceiver: serialises DWIDTH-bit words on o_z, deserialises from i_a into an RX FIFO.
// Latency: a TX frame lasts (DWIDTH+2)*P cycles; an RX word is visible 1 cycle after its stop-bit sample.
// Backpressure: o_tx_ready is low for the whole TX frame; a full RX FIFO without a pop drops the word and sets o_rx_ovf.
// Optional even-parity bit is enabled by defining WPIN_UART_PARITY_EN.

// Generic FIFO with a registered head output and pass-through when a push lands on the new head slot.
// Latency: a push shows up on empty/head_dat 1 cycle later.
// Backpressure: a push while full is accepted only together with a same-cycle pop.
module wpin_uart_xcvr_fifo #(
    parameter int unsigned W     = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head_dat
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, rd_ptr_n;
    logic          push_ok, pop_ok;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok   = pop & ~empty;
    assign push_ok  = push & (~full | pop_ok);
    assign rd_ptr_n = rd_ptr + (AW+1)'(pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            head_dat <= '0;
        end else begin
            wr_ptr <= wr_ptr + (AW+1)'(push_ok);
            rd_ptr <= rd_ptr_n;
            // The incoming word becomes the head when it lands on the slot being read next.
            if (push_ok && (wr_ptr[AW-1:0] == rd_ptr_n[AW-1:0])) begin
                head_dat <= push_dat;
            end else begin
                head_dat <= mem[rd_ptr_n[AW-1:0]];
            end
        end
    end
endmodule

module wpin_uart_xcvr #(
    parameter int unsigned DWIDTH   = 64,
    parameter int unsigned DIV_W    = 8,
    parameter int unsigned RX_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DIV_W-1:0]  i_div,
    input  logic              i_tx_valid,
    output logic              o_tx_ready,
    input  logic [DWIDTH-1:0] i_tx_data,
    output logic              o_z,
    input  logic              i_a,
    output logic              o_rx_valid,
    input  logic              i_rx_ready,
    output logic [DWIDTH-1:0] o_rx_data,
    output logic              o_rx_ovf,
    output logic              o_rx_err,
    input  logic              i_clr
);
    localparam int unsigned        BCW     = $clog2(DWIDTH + 1);
    localparam logic [BCW-1:0]     TX_LAST = BCW'(DWIDTH);
    localparam logic [BCW-1:0]     RX_LAST = BCW'(DWIDTH - 1);
    localparam logic [BCW-1:0]     BIT_ONE = BCW'(1);
    localparam logic [DIV_W-1:0]   CNT_ONE = DIV_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } st_t;

    // ---------------- TX ----------------
    st_t               tx_state, tx_state_n;
    logic [DIV_W-1:0]  tx_cnt, tx_cnt_n, tx_p, tx_p_n;
    logic [BCW-1:0]    tx_bits, tx_bits_n;
    logic [DWIDTH-1:0] tx_shift, tx_shift_n;
    logic              tx_z, tx_z_n;
`ifdef WPIN_UART_PARITY_EN
    logic              tx_par, tx_par_n;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_p     <= '0;
            tx_bits  <= '0;
            tx_shift <= '0;
            tx_z     <= 1'b0;
`ifdef WPIN_UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_p     <= tx_p_n;
            tx_bits  <= tx_bits_n;
            tx_shift <= tx_shift_n;
            tx_z     <= tx_z_n;
`ifdef WPIN_UART_PARITY_EN
            tx_par   <= tx_par_n;
`endif
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_p_n     = tx_p;
        tx_bits_n  = tx_bits;
        tx_shift_n = tx_shift;
        tx_z_n     = tx_z;
`ifdef WPIN_UART_PARITY_EN
        tx_par_n   = tx_par;
`endif
        case (tx_state)
            ST_IDLE: begin
                if (i_tx_valid) begin
                    tx_state_n = ST_START;
                    tx_cnt_n   = i_div;
                    tx_p_n     = i_div;
                    tx_shift_n = i_tx_data;
                    tx_bits_n  = '0;
                    tx_z_n     = 1'b1;
`ifdef WPIN_UART_PARITY_EN
                    tx_par_n   = ^i_tx_data;
`endif
                end
            end
            ST_START: begin
                if (tx_cnt == '0) begin
                    tx_state_n = ST_DATA;
                    tx_cnt_n   = tx_p;
                    tx_z_n     = tx_shift[DWIDTH-1];
                    tx_shift_n = {tx_shift[DWIDTH-2:0], 1'b0};
                    tx_bits_n  = BIT_ONE;
                end else begin
                    tx_cnt_n = tx_cnt - CNT_ONE;
                end
            end
            ST_DATA: begin
                if (tx_cnt == '0) begin
                    tx_cnt_n = tx_p;
                    if (tx_bits == TX_LAST) begin
`ifdef WPIN_UART_PARITY_EN
                        tx_state_n = ST_PAR;
                        tx_z_n     = tx_par;
`else
                        tx_state_n = ST_STOP;
                        tx_z_n     = 1'b0;
`endif
                    end else begin
                        tx_z_n     = tx_shift[DWIDTH-1];
                        tx_shift_n = {tx_shift[DWIDTH-2:0], 1'b0};
                        tx_bits_n  = tx_bits + BIT_ONE;
                    end
                end else begin
                    tx_cnt_n = tx_cnt - CNT_ONE;
                end
            end
`ifdef WPIN_UART_PARITY_EN
            ST_PAR: begin
                if (tx_cnt == '0) begin
                    tx_state_n = ST_STOP;
                    tx_cnt_n   = tx_p;
                    tx_z_n     = 1'b0;
                end else begin
                    tx_cnt_n = tx_cnt - CNT_ONE;
                end
            end
`endif
            ST_STOP: begin
                if (tx_cnt == '0) begin
                    tx_state_n = ST_IDLE;
                end else begin
                    tx_cnt_n = tx_cnt - CNT_ONE;
                end
            end
            default: tx_state_n = ST_IDLE;
        endcase
    end

    assign o_z        = tx_z;
    assign o_tx_ready = (tx_state == ST_IDLE);

    // ---------------- RX ----------------
    logic [2:0]        a_sync;
    logic              a_s, a_rise;
    st_t               rx_state, rx_state_n;
    logic [DIV_W-1:0]  rx_cnt, rx_cnt_n, rx_p, rx_p_n;
    logic [BCW-1:0]    rx_bits, rx_bits_n;
    logic [DWIDTH-1:0] rx_shift, rx_shift_n;
    logic              rx_push, rx_frm_err;
`ifdef WPIN_UART_PARITY_EN
    logic              rx_par, rx_par_n, rx_par_bad, rx_par_bad_n;
`endif
    logic              fifo_full, fifo_empty, rx_pop;

    // a_sync[1] is the synchronised line, a_sync[2] its previous value for edge detection.
    assign a_s    = a_sync[1];
    assign a_rise = a_sync[1] & ~a_sync[2];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            a_sync     <= '0;
            rx_state   <= ST_IDLE;
            rx_cnt     <= '0;
            rx_p       <= '0;
            rx_bits    <= '0;
            rx_shift   <= '0;
`ifdef WPIN_UART_PARITY_EN
            rx_par     <= 1'b0;
            rx_par_bad <= 1'b0;
`endif
        end else begin
            a_sync     <= {a_sync[1:0], i_a};
            rx_state   <= rx_state_n;
            rx_cnt     <= rx_cnt_n;
            rx_p       <= rx_p_n;
            rx_bits    <= rx_bits_n;
            rx_shift   <= rx_shift_n;
`ifdef WPIN_UART_PARITY_EN
            rx_par     <= rx_par_n;
            rx_par_bad <= rx_par_bad_n;
`endif
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_p_n     = rx_p;
        rx_bits_n  = rx_bits;
        rx_shift_n = rx_shift;
        rx_push    = 1'b0;
        rx_frm_err = 1'b0;
`ifdef WPIN_UART_PARITY_EN
        rx_par_n     = rx_par;
        rx_par_bad_n = rx_par_bad;
`endif
        case (rx_state)
            ST_IDLE: begin
                if (a_rise) begin
                    rx_state_n = ST_START;
                    rx_p_n     = i_div;
                    // ((i_div+1)>>1)-1 cycles to the mid-point of the start bit
                    rx_cnt_n   = (i_div >> 1) - {{(DIV_W-1){1'b0}}, ~i_div[0]};
                end
            end
            ST_START: begin
                if (rx_cnt == '0) begin
                    if (a_s) begin
                        rx_state_n = ST_DATA;
                        rx_cnt_n   = rx_p;
                        rx_bits_n  = '0;
`ifdef WPIN_UART_PARITY_EN
                        rx_par_n   = 1'b0;
`endif
                    end else begin
                        rx_state_n = ST_IDLE;
                    end
                end else begin
                    rx_cnt_n = rx_cnt - CNT_ONE;
                end
            end
            ST_DATA: begin
                if (rx_cnt == '0) begin
                    rx_shift_n = {rx_shift[DWIDTH-2:0], a_s};
                    rx_cnt_n   = rx_p;
`ifdef WPIN_UART_PARITY_EN
                    rx_par_n   = rx_par ^ a_s;
`endif
                    if (rx_bits == RX_LAST) begin
`ifdef WPIN_UART_PARITY_EN
                        rx_state_n = ST_PAR;
`else
                        rx_state_n = ST_STOP;
`endif
                    end else begin
                        rx_bits_n = rx_bits + BIT_ONE;
                    end
                end else begin
                    rx_cnt_n = rx_cnt - CNT_ONE;
                end
            end
`ifdef WPIN_UART_PARITY_EN
            ST_PAR: begin
                if (rx_cnt == '0) begin
                    rx_par_bad_n = a_s ^ rx_par;
                    rx_state_n   = ST_STOP;
                    rx_cnt_n     = rx_p;
                end else begin
                    rx_cnt_n = rx_cnt - CNT_ONE;
                end
            end
`endif
            ST_STOP: begin
                if (rx_cnt == '0) begin
                    rx_state_n = ST_IDLE;
`ifdef WPIN_UART_PARITY_EN
                    if (a_s | rx_par_bad) begin
`else
                    if (a_s) begin
`endif
                        rx_frm_err = 1'b1;
                    end else begin
                        rx_push = 1'b1;
                    end
                end else begin
                    rx_cnt_n = rx_cnt - CNT_ONE;
                end
            end
            default: rx_state_n = ST_IDLE;
        endcase
    end

    assign o_rx_valid = ~fifo_empty;
    assign rx_pop     = o_rx_valid & i_rx_ready;

    wpin_uart_xcvr_fifo #(
        .W     (DWIDTH),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk      (i_clk),
        .rst      (i_rst),
        .push     (rx_push),
        .push_dat (rx_shift_n),
        .pop      (rx_pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head_dat (o_rx_data)
    );

    // Sticky flags: a set event outranks a same-cycle clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rx_ovf <= 1'b0;
            o_rx_err <= 1'b0;
        end else begin
            o_rx_ovf <= (rx_push & fifo_full & ~rx_pop) | (o_rx_ovf & ~i_clr);
            o_rx_err <= rx_frm_err | (o_rx_err & ~i_clr);
        end
    end
endmodule
